// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Load-use stall sequencer states.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } loadState_e;

    // Hazard outputs are active-high: 1 means hazard detected / action taken.
    localparam logic HAZ_ON  = 1'b1;
    localparam logic HAZ_OFF = 1'b0;

    // Width of a down-counter that must hold the larger of the two latencies.
    function automatic int cntWidth(input int loadLat, input int mdLat);
        int maxLat;
        maxLat = (loadLat > mdLat) ? loadLat : mdLat;
        return $clog2(maxLat + 1);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signal bundle seen by the hazard controller.
interface hazard_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2
);
    logic                       inMemRead;
    logic [REG_W-1:0]           inIDEXRt;
    logic [NUM_SRC*REG_W-1:0]   inIFIDSrc;
    logic [NUM_SRC-1:0]         inIFIDSrcUsed;
    logic                       inMDStart;
    logic                       inIFIDUsesHiLo;
    logic                       inBranchTaken;
    logic                       hazardPCWrite;
    logic                       hazardIFIDWrite;
    logic                       hazardMux;
    logic                       hazardIFIDFlush;
    logic                       outMDBusy;

    // Pipeline side: presents instruction info, consumes stall/flush controls.
    modport master (
        output inMemRead, inIDEXRt, inIFIDSrc, inIFIDSrcUsed,
               inMDStart, inIFIDUsesHiLo, inBranchTaken,
        input  hazardPCWrite, hazardIFIDWrite, hazardMux,
               hazardIFIDFlush, outMDBusy
    );

    // Hazard controller side.
    modport slave (
        input  inMemRead, inIDEXRt, inIFIDSrc, inIFIDSrcUsed,
               inMDStart, inIFIDUsesHiLo, inBranchTaken,
        output hazardPCWrite, hazardIFIDWrite, hazardMux,
               hazardIFIDFlush, outMDBusy
    );
endinterface

// File: rtl/hazard_match.sv
// Single ID-source versus load-destination comparison; $zero never matches.
module hazard_match #(
    parameter int REG_W = 5
) (
    input  logic             inUsed,
    input  logic [REG_W-1:0] inSrc,
    input  logic [REG_W-1:0] inRt,
    output logic             outMatch
);

    // Source must be read, nonzero, and equal to the load destination.
    always_comb begin
        outMatch = inUsed && (inSrc != '0) && (inSrc == inRt);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall sequencing, mult/div busy tracking and
// branch flush generation. Outputs are Mealy: registered state plus current
// pipeline inputs, so a hazard stalls in the cycle it is presented.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 32
) (
    input  logic    Clk,
    input  logic    Rst,
    hazard_if.slave hz
);

    localparam int CW = cntWidth(LOAD_LAT, MD_LAT);

    logic [NUM_SRC-1:0] srcMatch_s;
    logic               loadHit_s;
    loadState_e         state_r;
    loadState_e         stateNext_s;
    logic [CW-1:0]      lcnt_r;
    logic [CW-1:0]      lcntNext_s;
    logic [CW-1:0]      mcnt_r;
    logic               loadStall_s;
    logic               mdBusy_s;
    logic               mdHit_s;
    logic               stall_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        hazard_match #(
            .REG_W (REG_W)
        ) uMatch (
            .inUsed   (hz.inIFIDSrcUsed[i]),
            .inSrc    (hz.inIFIDSrc[i*REG_W +: REG_W]),
            .inRt     (hz.inIDEXRt),
            .outMatch (srcMatch_s[i])
        );
    end

    // A load in EX feeding any live ID source is a load-use hazard.
    always_comb begin
        loadHit_s = hz.inMemRead && (|srcMatch_s);
    end

    // Load FSM state and remaining-stall counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= RUN;
            lcnt_r  <= '0;
        end else begin
            state_r <= stateNext_s;
            lcnt_r  <= lcntNext_s;
        end
    end

    // Load FSM next state; LSTALL stalls blindly and ignores the EX-stage load.
    always_comb begin
        stateNext_s = state_r;
        lcntNext_s  = lcnt_r;
        loadStall_s = HAZ_OFF;
        case (state_r)
            RUN: begin
                if (loadHit_s) begin
                    loadStall_s = HAZ_ON;
                    if (LOAD_LAT > 1) begin
                        stateNext_s = LSTALL;
                        lcntNext_s  = CW'(LOAD_LAT - 1);
                    end else begin
                        stateNext_s = RUN;
                        lcntNext_s  = '0;
                    end
                end else begin
                    stateNext_s = RUN;
                    lcntNext_s  = '0;
                end
            end
            LSTALL: begin
                loadStall_s = HAZ_ON;
                if (lcnt_r <= CW'(1'b1)) begin
                    stateNext_s = RUN;
                    lcntNext_s  = '0;
                end else begin
                    stateNext_s = LSTALL;
                    lcntNext_s  = lcnt_r - CW'(1'b1);
                end
            end
            default: begin
                stateNext_s = RUN;
                lcntNext_s  = '0;
            end
        endcase
    end

    // Mult/div busy counter; a new issue reloads the full latency.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mcnt_r <= '0;
        end else if (hz.inMDStart) begin
            mcnt_r <= CW'(MD_LAT);
        end else if (mcnt_r != '0) begin
            mcnt_r <= mcnt_r - CW'(1'b1);
        end else begin
            mcnt_r <= mcnt_r;
        end
    end

    // Combine hazards; a stalled branch is not flushed, it retries after the stall.
    always_comb begin
        mdBusy_s = (mcnt_r != '0);
        mdHit_s  = mdBusy_s && hz.inIFIDUsesHiLo;
        stall_s  = loadStall_s || mdHit_s;
        if (Rst) begin
            hz.hazardPCWrite   = HAZ_OFF;
            hz.hazardIFIDWrite = HAZ_OFF;
            hz.hazardMux       = HAZ_OFF;
            hz.hazardIFIDFlush = HAZ_OFF;
            hz.outMDBusy       = HAZ_OFF;
        end else begin
            hz.hazardPCWrite   = stall_s;
            hz.hazardIFIDWrite = stall_s;
            hz.hazardMux       = stall_s;
            hz.hazardIFIDFlush = hz.inBranchTaken && !stall_s;
            hz.outMDBusy       = mdBusy_s;
        end
    end

endmodule
